crc32_tx_serializer: RTL
========================

# crc32_tx_serializer

Upstream feeder for the bit-serial CRC-32 engine on the transmit path. Accepts frame bytes over a valid/ready stream, shifts them out LSB-first as a serial bit stream, and drives the engine's init, enable and data inputs in lockstep. After the last data bit it captures the engine's result and appends the 32-bit FCS (complemented CRC, bit 31 first), so the line carries a complete Ethernet-style frame.

## Interface
- FCS_INVERT, 1, 1: transmit ~CRC as FCS; 0: transmit CRC unmodified.
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- S_DATA  in  8  frame byte.
- S_VALID  in  1  S_DATA valid.
- S_LAST  in  1  S_DATA is the final byte of the frame.
- S_READY  out  1  byte accepted when S_VALID & S_READY.
- TX_BIT  out  1  serial line bit.
- TX_VALID  out  1  TX_BIT carries a frame bit (data or FCS).
- TX_EOF  out  1  high on the final FCS bit.
- ABORT  out  1  one-cycle pulse on underrun.
- CRC_Init  out  1  to engine: load init value.
- CRC_ENABLE  out  1  to engine: consume DATA_Serial_Stream.
- DATA_Serial_Stream  out  1  to engine: current data bit.
- CRC_Resault  in  32  from engine: CRC including the bit currently presented.
- FCS  out  32  FCS value of the last completed frame, held until the next one.

## Operation
- All outputs registered except S_READY (decoded from state/bit counter). Reset: state IDLE, TX_BIT=0, TX_VALID=0, TX_EOF=0, ABORT=0, CRC_ENABLE=0, DATA_Serial_Stream=0, CRC_Init=1, FCS=0, S_READY=1 in the cycle after reset deasserts.
- States: IDLE, DATA, FCS. Internal: 8-bit shift register, last flag, 3-bit bit counter, 5-bit FCS counter, 32-bit FCS register.
- IDLE: CRC_Init=1, CRC_ENABLE=0, TX_VALID=0, S_READY=1. A handshake loads the byte and S_LAST; next state DATA, bit 0.
- DATA: each cycle TX_BIT = DATA_Serial_Stream = shreg[bit_cnt], TX_VALID=1, CRC_ENABLE=1, CRC_Init=0; bit_cnt increments and wraps 7→0.
- S_READY=1 in DATA only while bit_cnt==7 and the current byte is not last. Handshake there: new byte loaded, bit 0 follows with no gap.
- Underrun: bit_cnt==7, not last, S_VALID=0. Next cycle: ABORT=1, TX_VALID=0, CRC_ENABLE=0, state IDLE; no FCS sent, FCS register unchanged.
- Last byte, bit_cnt==7: FCS register ← FCS_INVERT ? ~CRC_Resault : CRC_Resault, sampled in that same cycle. Next state FCS, fcs_cnt=0.
- FCS: TX_BIT = fcs_reg[31-fcs_cnt], TX_VALID=1, CRC_ENABLE=0, CRC_Init=0, DATA_Serial_Stream=0. At fcs_cnt==31: TX_EOF=1, then IDLE.
- RST during any state: immediate return to reset values on the next edge. The partial frame is dropped and ABORT is not pulsed.

## Timing
- Byte accepted at edge t: its bit 0 is on TX_BIT/DATA_Serial_Stream in cycle t+1. The engine registers it at edge t+2.
- Frame of N bytes: TX_VALID high for exactly 8N+32 consecutive cycles. The first bit follows the first-byte handshake by one cycle.
- Back-to-back frames: at least one IDLE cycle (TX_VALID=0, CRC_Init=1) between TX_EOF and the next frame's first bit. This guarantees engine re-initialisation.
- FCS output updates on the edge ending the last data bit; stable throughout the FCS phase.
- S_VALID held without S_READY: byte not consumed; upstream must hold S_DATA/S_LAST stable.

## Test plan
- Frame "123456789" (0x31..0x39, S_LAST on 0x39), continuous valid: 72 data bits LSB-first, then FCS=0x649C2FD3 sent MSB-first. The line then equals 0x26,0x39,0xF4,0xCB LSB-first; TX_EOF on the 104th TX_VALID cycle.
- Single-byte frame 0x00: 8 zero bits then 32 FCS bits. Feeding all 40 line bits into a fresh engine gives residue CRC register 0xC704DD7B.
- Underrun: 2-byte frame with S_VALID low at the first byte's bit 7. ABORT pulses once, TX_VALID drops after 8 bits, no FCS, FCS output unchanged. A subsequent "123456789" frame still yields 0x649C2FD3.
- Backpressure: S_VALID high with a new frame during the FCS phase. The byte is taken only in IDLE; exactly one TX_VALID=0 cycle between frames.
- RST asserted mid-data (byte 3, bit 4): all outputs return to reset values next cycle and CRC_Init=1. The next frame's FCS is correct.
- Random frames of 1–64 bytes with random S_VALID gaps between (never inside) frames: FCS matches the reference CRC-32 model on every frame.

Source files
------------

// File: rtl/crc32_tx_serializer.sv
// crc32_tx_serializer: serialises frame bytes LSB-first into a bit-serial CRC-32 engine and appends the 32-bit FCS
//   CLK, RST                 clock and synchronous active-high reset
//   S_DATA/S_VALID/S_LAST    byte stream in, S_READY back-pressure out
//   TX_BIT/TX_VALID/TX_EOF   serial line out; ABORT pulses on underrun
//   CRC_Init/CRC_ENABLE/DATA_Serial_Stream  engine control; CRC_Resault engine result in
//   FCS                      FCS of the last completed frame
module crc32_tx_serializer #(
  parameter bit FCS_INVERT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  S_DATA,
  input  logic        S_VALID,
  input  logic        S_LAST,
  output logic        S_READY,
  output logic        TX_BIT,
  output logic        TX_VALID,
  output logic        TX_EOF,
  output logic        ABORT,
  output logic        CRC_Init,
  output logic        CRC_ENABLE,
  output logic        DATA_Serial_Stream,
  input  logic [31:0] CRC_Resault,
  output logic [31:0] FCS
);
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_FCS} state_t;
  state_t      state_q;
  logic [7:0]  shreg_q;
  logic        last_q;
  logic [2:0]  bit_q;
  logic [4:0]  fcs_cnt_q;
  logic [31:0] fcs_q;
  logic        tx_bit_q, tx_valid_q, tx_eof_q, abort_q, crc_init_q, crc_en_q, dss_q;
  logic [31:0] fcs_d;
  logic [2:0]  bit_d;
  logic [4:0]  fcs_cnt_d;
  logic        take;
  // CRC_Resault already includes the bit on the line, so sampling it while bit 7 of the last byte is presented captures the whole frame
  assign fcs_d     = FCS_INVERT ? ~CRC_Resault : CRC_Resault;
  assign bit_d     = bit_q + 3'd1;
  assign fcs_cnt_d = fcs_cnt_q + 5'd1;
  assign S_READY   = (state_q == ST_IDLE) || (state_q == ST_DATA && bit_q == 3'd7 && !last_q);
  assign take      = S_VALID && S_READY;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      bit_q      <= '0;
      fcs_cnt_q  <= '0;
      fcs_q      <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_eof_q   <= 1'b0;
      abort_q    <= 1'b0;
      crc_init_q <= 1'b1;
      crc_en_q   <= 1'b0;
      dss_q      <= 1'b0;
    end else begin
      abort_q  <= 1'b0;
      tx_eof_q <= 1'b0;
      if (take) begin
        state_q    <= ST_DATA;
        shreg_q    <= S_DATA;
        last_q     <= S_LAST;
        bit_q      <= '0;
        tx_bit_q   <= S_DATA[0];
        dss_q      <= S_DATA[0];
        tx_valid_q <= 1'b1;
        crc_en_q   <= 1'b1;
        crc_init_q <= 1'b0;
      end else begin
        case (state_q)
          ST_DATA: begin
            bit_q <= bit_d;
            if (bit_q != 3'd7) begin
              tx_bit_q <= shreg_q[bit_d];
              dss_q    <= shreg_q[bit_d];
            end else if (last_q) begin
              state_q   <= ST_FCS;
              fcs_q     <= fcs_d;
              fcs_cnt_q <= '0;
              tx_bit_q  <= fcs_d[31];
              dss_q     <= 1'b0;
              crc_en_q  <= 1'b0;
            end else begin
              // underrun: drop the frame, engine is re-initialised from IDLE
              state_q    <= ST_IDLE;
              abort_q    <= 1'b1;
              tx_valid_q <= 1'b0;
              tx_bit_q   <= 1'b0;
              dss_q      <= 1'b0;
              crc_en_q   <= 1'b0;
              crc_init_q <= 1'b1;
            end
          end
          ST_FCS: begin
            if (fcs_cnt_q != 5'd31) begin
              fcs_cnt_q <= fcs_cnt_d;
              tx_bit_q  <= fcs_q[~fcs_cnt_d];
              tx_eof_q  <= fcs_cnt_d == 5'd31;
            end else begin
              state_q    <= ST_IDLE;
              tx_valid_q <= 1'b0;
              tx_bit_q   <= 1'b0;
              crc_init_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
  assign TX_BIT             = tx_bit_q;
  assign TX_VALID           = tx_valid_q;
  assign TX_EOF             = tx_eof_q;
  assign ABORT              = abort_q;
  assign CRC_Init           = crc_init_q;
  assign CRC_ENABLE         = crc_en_q;
  assign DATA_Serial_Stream = dss_q;
  assign FCS                = fcs_q;
endmodule
